fetch_unit: RTL and testbench

//  Instruction-fetch stage of the 32-bit CPU. Owns the program counter, drives the word

---
 rtl/cpu_pkg.sv | 40 ++++
 rtl/fetch_next_pc.sv | 38 +++
 rtl/fetch_unit.sv | 109 ++++++++++
 tb/tb_fetch_unit.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode encodings, instruction field positions and the
// fetch-stage state encoding.
package cpu_pkg;

    localparam logic [2:0] OP_NOOP   = 3'b000;
    localparam logic [2:0] OP_J      = 3'b001;
    localparam logic [2:0] OP_ADD    = 3'b010;
    localparam logic [2:0] OP_BEQ    = 3'b011;
    localparam logic [2:0] OP_SHIFTL = 3'b100;
    localparam logic [2:0] OP_ADDI   = 3'b110;
    localparam logic [2:0] OP_SUBI   = 3'b111;

    localparam int OPC_MSB   = 31;
    localparam int OPC_LSB   = 29;
    localparam int RS_MSB    = 28;
    localparam int RS_LSB    = 24;
    localparam int RT_MSB    = 23;
    localparam int RT_LSB    = 19;
    localparam int RD_MSB    = 18;
    localparam int RD_LSB    = 14;
    localparam int IMM16_MSB = 15;
    localparam int IMM16_LSB = 0;
    localparam int JTGT_MSB  = 11;
    localparam int JTGT_LSB  = 0;

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

    function automatic logic [2:0] opcode_of(input logic [31:0] instr);
        return instr[OPC_MSB:OPC_LSB];
    endfunction

    function automatic logic is_jump(input logic [31:0] instr);
        return opcode_of(instr) == OP_J;
    endfunction

endpackage

// File: rtl/fetch_next_pc.sv
// Next program-counter selection for the fetch stage: redirect, local J resolution,
// sequential increment, or hold.
module fetch_next_pc
    import cpu_pkg::*;
#(
    parameter int JMP_TGT_W = 12
) (
    input  logic [31:0] pc,
    input  logic [31:0] imem_instr,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        cap,
    output logic [31:0] pc_next
);

    logic [31:0] jump_tgt_s;
    logic        unused_instr_s;

    assign jump_tgt_s     = 32'(imem_instr[JMP_TGT_W-1:0]);
    assign unused_instr_s = ^imem_instr;

    // Redirect has priority; a captured J jumps, any other captured word steps by one.
    always_comb begin
        pc_next = pc;
        if (redirect_valid) begin
            pc_next = redirect_pc;
        end else if (cap) begin
            if (is_jump(imem_instr)) begin
                pc_next = jump_tgt_s;
            end else begin
                pc_next = pc + 32'd1;
            end
        end else begin
            pc_next = pc;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, addresses instruction memory and holds the
// IF/ID register behind a valid/ready handshake toward decode.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'd0,
    parameter int          JMP_TGT_W = 12
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        halt_req,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic [31:0] fetch_count
);

    fetch_state_t state_r;
    fetch_state_t state_next_s;
    logic [31:0]  pc_r;
    logic [31:0]  pc_next_s;
    logic         out_valid_r;
    logic [31:0]  out_instr_r;
    logic [31:0]  out_pc_r;
    logic [31:0]  fetch_count_r;
    logic         cap_s;

    assign imem_addr   = pc_r;
    assign out_valid   = out_valid_r;
    assign out_instr   = out_instr_r;
    assign out_pc      = out_pc_r;
    assign fetch_count = fetch_count_r;

    // Capture only while running, not being flushed, and with room in IF/ID.
    assign cap_s = (state_r == RUN) && !redirect_valid && (!out_valid_r || out_ready);

    fetch_next_pc #(
        .JMP_TGT_W(JMP_TGT_W)
    ) u_next_pc (
        .pc            (pc_r),
        .imem_instr    (imem_instr),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .cap           (cap_s),
        .pc_next       (pc_next_s)
    );

    // Fetch FSM next state; a redirect always lands in RUN, halt only leaves RUN.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            BOOT: begin
                state_next_s = RUN;
            end
            RUN: begin
                if (redirect_valid) begin
                    state_next_s = RUN;
                end else if (halt_req) begin
                    state_next_s = HALTED;
                end else begin
                    state_next_s = RUN;
                end
            end
            HALTED: begin
                if (redirect_valid) begin
                    state_next_s = RUN;
                end else begin
                    state_next_s = HALTED;
                end
            end
            default: begin
                state_next_s = BOOT;
            end
        endcase
    end

    // State, PC, IF/ID register and capture counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= BOOT;
            pc_r          <= RESET_PC;
            out_valid_r   <= 1'b0;
            out_instr_r   <= 32'd0;
            out_pc_r      <= 32'd0;
            fetch_count_r <= 32'd0;
        end else begin
            state_r <= state_next_s;
            pc_r    <= pc_next_s;
            if (redirect_valid) begin
                out_valid_r <= 1'b0;
            end else if (cap_s) begin
                out_valid_r   <= 1'b1;
                out_instr_r   <= imem_instr;
                out_pc_r      <= pc_r;
                fetch_count_r <= fetch_count_r + 32'd1;
            end else if (out_valid_r && out_ready) begin
                out_valid_r <= 1'b0;
            end else begin
                out_valid_r <= out_valid_r;
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: stimulus pushes expected {pc} transfers into a queue,
// a negedge monitor pops and compares every accepted IF/ID transfer.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        halt_req = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [31:0] fetch_count;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] exp_q[$];
    logic [31:0] mon_exp;

    always #5 clk = ~clk;

    // Program image: J at 5 -> 12, loop 14..21 closed by J at 21 -> 14, NOOP at 22.
    function automatic logic [31:0] prog(input logic [31:0] a);
        case (a)
            32'd0:   return 32'hC040_0005;
            32'd1:   return 32'h4088_4000;
            32'd2:   return 32'h6100_0003;
            32'd3:   return 32'h8188_0002;
            32'd4:   return 32'hE210_0001;
            32'd5:   return 32'h2000_000C;
            32'd6:   return 32'h4FFF_FFFF;
            32'd12:  return 32'hC0C0_0010;
            32'd13:  return 32'h4000_0001;
            32'd21:  return 32'h2000_000E;
            32'd22:  return 32'h0000_0000;
            default: return {3'b010, a[28:0]};
        endcase
    endfunction

    assign imem_instr = prog(imem_addr);

    fetch_unit #(
        .RESET_PC (32'd0),
        .JMP_TGT_W(12)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .imem_addr     (imem_addr),
        .imem_instr    (imem_instr),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .halt_req      (halt_req),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_instr     (out_instr),
        .out_pc        (out_pc),
        .fetch_count   (fetch_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic push_range(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            exp_q.push_back(32'(i));
        end
    endtask

    // Reset, check the reset image, release and pass the single BOOT cycle.
    task automatic do_reset(input logic halt_in_boot);
        check("queue drained", 32'(exp_q.size()), 32'd0);
        reset = 1'b1;
        out_ready = 1'b0;
        redirect_valid = 1'b0;
        halt_req = 1'b0;
        step;
        step;
        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst out_pc", out_pc, 32'd0);
        check("rst out_instr", out_instr, 32'd0);
        check("rst fetch_count", fetch_count, 32'd0);
        check("rst imem_addr", imem_addr, 32'd0);
        reset = 1'b0;
        out_ready = 1'b1;
        halt_req = halt_in_boot;
        step;
        halt_req = 1'b0;
        check("boot out_valid", 32'(out_valid), 32'd0);
        check("boot fetch_count", fetch_count, 32'd0);
        check("boot imem_addr", imem_addr, 32'd0);
    endtask

    // Monitor: every accepted transfer must match the head of the expected queue.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected transfer: got pc %h, expected no transfer", out_pc);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("xfer pc", out_pc, mon_exp);
                    check("xfer instr", out_instr, prog(mon_exp));
                end
            end
        end
    end

    initial begin
        // Boot sequence through J at 5, then around the 14..21 loop with no bubble.
        do_reset(1'b1);
        push_range(0, 5);
        push_range(12, 21);
        exp_q.push_back(32'd14);
        for (int k = 0; k < 18; k++) begin
            step;
            check("t1 no bubble", 32'(out_valid), 32'd1);
            check("t1 fetch_count", fetch_count, 32'(k + 1));
        end
        check("t2 pc after loop", out_pc, 32'd15);

        // Decode stall at out_pc=2 for three cycles.
        do_reset(1'b0);
        push_range(0, 2);
        step;
        step;
        step;
        check("t3 pre-stall pc", out_pc, 32'd2);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step;
            check("t3 hold valid", 32'(out_valid), 32'd1);
            check("t3 hold pc", out_pc, 32'd2);
            check("t3 hold instr", out_instr, prog(32'd2));
            check("t3 hold imem_addr", imem_addr, 32'd3);
            check("t3 hold count", fetch_count, 32'd3);
        end
        out_ready = 1'b1;
        step;
        check("t3 release pc", out_pc, 32'd3);
        check("t3 release count", fetch_count, 32'd4);

        // Redirect to 22 while out_pc=17 is stalled.
        do_reset(1'b0);
        push_range(0, 5);
        push_range(12, 16);
        for (int i = 0; i < 12; i++) begin
            step;
        end
        check("t4 pc before redirect", out_pc, 32'd17);
        check("t4 count before redirect", fetch_count, 32'd12);
        out_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 32'd22;
        step;
        check("t4 flush valid", 32'(out_valid), 32'd0);
        check("t4 redirect addr", imem_addr, 32'd22);
        check("t4 flush count", fetch_count, 32'd12);
        redirect_valid = 1'b0;
        out_ready = 1'b1;
        exp_q.push_back(32'd22);
        step;
        check("t4 target pc", out_pc, 32'd22);
        check("t4 noop instr", out_instr, 32'd0);
        check("t4 target count", fetch_count, 32'd13);
        step;
        check("t4 after target pc", out_pc, 32'd23);

        // Halt pulse at pc=3, then resume via redirect to 12.
        do_reset(1'b0);
        push_range(0, 3);
        exp_q.push_back(32'd12);
        step;
        step;
        step;
        check("t5 addr at halt", imem_addr, 32'd3);
        halt_req = 1'b1;
        step;
        halt_req = 1'b0;
        check("t5 halt capture pc", out_pc, 32'd3);
        check("t5 halt capture valid", 32'(out_valid), 32'd1);
        check("t5 halt capture count", fetch_count, 32'd4);
        for (int i = 0; i < 3; i++) begin
            step;
            check("t5 halted valid", 32'(out_valid), 32'd0);
            check("t5 halted count", fetch_count, 32'd4);
            check("t5 halted addr", imem_addr, 32'd4);
        end
        redirect_valid = 1'b1;
        redirect_pc = 32'd12;
        step;
        redirect_valid = 1'b0;
        check("t5 resume valid", 32'(out_valid), 32'd0);
        check("t5 resume addr", imem_addr, 32'd12);
        step;
        check("t5 resume pc", out_pc, 32'd12);
        check("t5 resume count", fetch_count, 32'd5);
        step;
        check("t5 next pc", out_pc, 32'd13);

        // Reset mid-loop, then redirect to the top word and wrap to 0.
        do_reset(1'b0);
        push_range(0, 5);
        push_range(12, 15);
        for (int i = 0; i < 11; i++) begin
            step;
        end
        check("t6 mid-loop pc", out_pc, 32'd16);
        do_reset(1'b0);
        step;
        check("t6 restart pc", out_pc, 32'd0);
        check("t6 restart count", fetch_count, 32'd1);
        out_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFFF;
        step;
        check("t6 flush valid", 32'(out_valid), 32'd0);
        check("t6 redirect addr", imem_addr, 32'hFFFF_FFFF);
        redirect_valid = 1'b0;
        out_ready = 1'b1;
        exp_q.push_back(32'hFFFF_FFFF);
        exp_q.push_back(32'd0);
        step;
        check("t6 top pc", out_pc, 32'hFFFF_FFFF);
        check("t6 wrap addr", imem_addr, 32'd0);
        check("t6 top count", fetch_count, 32'd2);
        step;
        check("t6 wrapped pc", out_pc, 32'd0);
        check("t6 wrapped count", fetch_count, 32'd3);
        step;
        check("t6 after wrap pc", out_pc, 32'd1);
        out_ready = 1'b0;
        step;
        check("final queue drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
